fetch_sequencer: RTL and testbench
==================================

# fetch_sequencer

Program-flow controller for the 9-bit miniMips core. It owns the program counter and the start/done handshake of `topLevel`. On a `start` pulse it clears the core, steps the PC through instruction memory, and applies relative branches, stalls and halts reported by the decoder. It raises `done` when the program halts or a watchdog expires. It sits between the top-level `start`/`done` pins and the instruction memory address port.

## Interface
- `PC_W`, default 8: PC width, which matches the 256-entry instruction memory.
- `OFF_W`, default 8: width of the signed branch offset.
- `MAX_CYCLES`, default 4096: watchdog limit on RUN cycles; legal range 2..65535.

Ports:
- `clk` in 1: the single clock; all state updates on the rising edge.
- `reset` in 1: asynchronous, active-high; forces all state to its reset value immediately.
- `start` in 1: run request, sampled on the clock; acted on only in IDLE or DONE.
- `start_addr` in PC_W: first instruction address, sampled in LOAD.
- `halt` in 1: decoder flags the instruction at `pc` as a halt.
- `br_take` in 1: decoder flags a taken branch at `pc`.
- `br_offset` in OFF_W: signed offset relative to `pc`, valid when `br_take` is high.
- `stall` in 1: core needs another cycle for the instruction at `pc`.
- `pc` out PC_W: instruction memory address.
- `instr_valid` out 1: high when the instruction at `pc` executes this cycle (state RUN).
- `core_rst` out 1: one-cycle clear pulse to the core register file and flags.
- `done` out 1: level signal, program finished.
- `timeout` out 1: finish was caused by the watchdog.
- `cycle_cnt` out 16: number of RUN cycles in the current or last run.

## Operation
States: IDLE, LOAD, RUN, DONE. Reset state is IDLE.

Reset values:
- `pc` = 0, `cycle_cnt` = 0.
- `instr_valid`, `core_rst`, `done` and `timeout` = 0.

Transitions:
- **IDLE** → LOAD on `start`.
- **LOAD** → RUN unconditionally.
  - Entry edge clears `cycle_cnt`, `done` and `timeout`.
  - In LOAD, `core_rst` = 1 and `instr_valid` = 0.
  - The exit edge loads `pc` <= `start_addr`.
- **RUN**: `instr_valid` = 1 and `cycle_cnt` increments every RUN cycle. Priority at each edge, highest first:
  1. `stall`: `pc` held; `halt` and `br_take` are ignored.
  2. `halt`: go to DONE with `pc` held.
  3. Watchdog: if `cycle_cnt` == MAX_CYCLES-1, go to DONE with `timeout` = 1 and `pc` held.
  4. `br_take`: `pc` <= `pc` + sign-extended `br_offset`.
  5. Otherwise `pc` <= `pc` + 1.
- **DONE**: `done` = 1, `instr_valid` = 0, and `pc`, `cycle_cnt` and `timeout` are held. `start` → LOAD.

Arithmetic and width rules:
- All PC arithmetic is modulo 2^PC_W. Incrementing from all-ones wraps to 0, and branch targets wrap the same way; neither is an error.
- `br_offset` is sign-extended (or truncated) to PC_W before the add.
- `cycle_cnt` counts the halting cycle and stall cycles. The watchdog bounds it, so it never exceeds MAX_CYCLES.

Boundary conditions:
- `start` in LOAD or RUN is ignored; there is no restart mid-run.
- `halt` together with `br_take` (no stall): halt wins.
- `halt` on the same cycle the watchdog fires: halt wins and `timeout` stays 0.
- `reset` in any state returns the block to IDLE with all reset values, asynchronously. The core must be restarted with `start`.
- `halt`, `br_take` and `stall` are don't-care outside RUN.

## Timing
- `start` high at edge T (in IDLE or DONE):
  - LOAD occupies cycle T..T+1.
  - First RUN cycle is T+1..T+2, with `pc` = `start_addr`.
- Fetch latency: each instruction occupies at least one RUN cycle, plus one extra cycle per asserted `stall`.
- A branch takes effect on the following cycle, with no delay slot.
- `halt` sampled at edge H: `done` = 1 from H onward, and `instr_valid` drops in the same cycle.
- `done` is a registered output with no combinational path from inputs.

## Test plan
- **Reset:** assert `reset` mid-clock, no edge → all outputs 0, state IDLE; `start` without `reset` later still works.
- **Straight-line halt:** `start_addr` = 0, `halt` at `pc` = 3.
  - `core_rst` high exactly 1 cycle.
  - `pc` sequence 0,1,2,3.
  - `done` = 1, `cycle_cnt` = 4, `timeout` = 0.
- **Branches:**
  - `br_take` with offset -2 at `pc` = 5 → next `pc` = 3.
  - Offset +4 at `pc` = 254 → `pc` = 2 (wrap).
  - `halt` and `br_take` together → DONE, `pc` unchanged.
- **Stall:** 3-cycle `stall` at `pc` = 2, with `halt` also high in those cycles.
  - `pc` held at 2 for 4 cycles; `halt` is ignored while stalled.
  - `cycle_cnt` includes the stall cycles.
- **Watchdog:** MAX_CYCLES = 8, no `halt` → DONE after exactly 8 RUN cycles, `timeout` = 1, `cycle_cnt` = 8. `halt` on cycle 8 instead → `timeout` = 0.
- **Start handling:**
  - `start` during RUN → ignored.
  - `start` in DONE → LOAD, `done` and `timeout` cleared, new run from the new `start_addr`.
  - `reset` during RUN → immediate IDLE.

Source files
------------

// File: rtl/fetch_sequencer_if.sv
// Fetch-sequencer bundle: run request, decoder flags and PC/status back to the core.
// Master is the sequencer; slave is the top-level/decoder side.
interface fetch_sequencer_if #(
  parameter int PC_W  = 8,
  parameter int OFF_W = 8
);
  logic             start;
  logic [PC_W-1:0]  start_addr;
  logic             halt;
  logic             br_take;
  logic [OFF_W-1:0] br_offset;
  logic             stall;
  logic [PC_W-1:0]  pc;
  logic             instr_valid;
  logic             core_rst;
  logic             done;
  logic             timeout;
  logic [15:0]      cycle_cnt;

  modport master (
    input  start, start_addr, halt, br_take, br_offset, stall,
    output pc, instr_valid, core_rst, done, timeout, cycle_cnt
  );

  modport slave (
    output start, start_addr, halt, br_take, br_offset, stall,
    input  pc, instr_valid, core_rst, done, timeout, cycle_cnt
  );
endinterface

// File: rtl/fetch_sequencer.sv
// Program-flow controller: LOAD clears the core, RUN steps the PC (1 cycle/instr + stalls), DONE on halt or watchdog.
// No backpressure beyond stall; all outputs decode registered state, so none has a combinational path from inputs.
module fetch_sequencer #(
  parameter int PC_W       = 8,
  parameter int OFF_W      = 8,
  parameter int MAX_CYCLES = 4096
) (
  input  logic               clk,
  input  logic               reset,
  fetch_sequencer_if.master  bus
);
  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_RUN, S_DONE} state_t;

  localparam logic [15:0] WD_LAST = 16'(MAX_CYCLES - 1);
  localparam logic [15:0] WD_MAX  = 16'(MAX_CYCLES);

  state_t          state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic [15:0]     cycle_cnt_q, cycle_cnt_d;
  logic            timeout_q, timeout_d;
  logic [PC_W-1:0] br_delta;

  // Signed size cast sign-extends a narrow offset and truncates a wide one.
  assign br_delta = PC_W'($signed(bus.br_offset));

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    cycle_cnt_d = cycle_cnt_q;
    timeout_d   = timeout_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (bus.start) begin
          state_d     = S_LOAD;
          cycle_cnt_d = 16'd0;
          timeout_d   = 1'b0;
        end
      end
      S_LOAD: begin
        state_d = S_RUN;
        pc_d    = bus.start_addr;
      end
      S_RUN: begin
        // Saturate so a stall held across the limit cannot push the count past MAX_CYCLES.
        if (cycle_cnt_q != WD_MAX) cycle_cnt_d = cycle_cnt_q + 16'd1;
        if (!bus.stall) begin
          if (bus.halt) begin
            state_d = S_DONE;
          end else if (cycle_cnt_q >= WD_LAST) begin
            state_d   = S_DONE;
            timeout_d = 1'b1;
          end else if (bus.br_take) begin
            pc_d = pc_q + br_delta;
          end else begin
            pc_d = pc_q + PC_W'(1);
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      pc_q        <= '0;
      cycle_cnt_q <= 16'd0;
      timeout_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      cycle_cnt_q <= cycle_cnt_d;
      timeout_q   <= timeout_d;
    end
  end

  assign bus.pc          = pc_q;
  assign bus.cycle_cnt   = cycle_cnt_q;
  assign bus.timeout     = timeout_q;
  assign bus.instr_valid = (state_q == S_RUN);
  assign bus.core_rst    = (state_q == S_LOAD);
  assign bus.done        = (state_q == S_DONE);
endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer: a per-cycle vector table plus hand-written reset and watchdog sequences.
module tb_fetch_sequencer;
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  fetch_sequencer_if #(.PC_W(8), .OFF_W(8)) ia();
  fetch_sequencer_if #(.PC_W(8), .OFF_W(8)) iw();

  fetch_sequencer #(.PC_W(8), .OFF_W(8), .MAX_CYCLES(4096)) dut_a (
    .clk(clk), .reset(reset), .bus(ia.master)
  );
  fetch_sequencer #(.PC_W(8), .OFF_W(8), .MAX_CYCLES(8)) dut_w (
    .clk(clk), .reset(reset), .bus(iw.master)
  );

  typedef struct {
    logic        start;
    logic [7:0]  addr;
    logic        halt;
    logic        br;
    logic [7:0]  off;
    logic        stall;
    logic [7:0]  e_pc;
    logic        e_vld;
    logic        e_rst;
    logic        e_done;
    logic        e_to;
    logic [15:0] e_cnt;
  } vec_t;

  vec_t tbl[19];
  int n_chk = 0;
  int n_fail = 0;

  function automatic vec_t mk(logic s, logic [7:0] a, logic h, logic b, logic [7:0] o, logic st,
                              logic [7:0] p, logic v, logic r, logic d, logic t, logic [15:0] c);
    vec_t x;
    x.start = s; x.addr = a; x.halt = h; x.br = b; x.off = o; x.stall = st;
    x.e_pc = p; x.e_vld = v; x.e_rst = r; x.e_done = d; x.e_to = t; x.e_cnt = c;
    return x;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic chk6(input string tag,
                      input logic [7:0] a_pc, input logic a_v, input logic a_r,
                      input logic a_d, input logic a_t, input logic [15:0] a_c,
                      input logic [7:0] e_pc, input logic e_v, input logic e_r,
                      input logic e_d, input logic e_t, input logic [15:0] e_c);
    chk({tag, ".pc"}, 32'(a_pc), 32'(e_pc));
    chk({tag, ".instr_valid"}, 32'(a_v), 32'(e_v));
    chk({tag, ".core_rst"}, 32'(a_r), 32'(e_r));
    chk({tag, ".done"}, 32'(a_d), 32'(e_d));
    chk({tag, ".timeout"}, 32'(a_t), 32'(e_t));
    chk({tag, ".cycle_cnt"}, 32'(a_c), 32'(e_c));
  endtask

  task automatic drive_a(input logic s, input logic [7:0] a, input logic h, input logic b,
                         input logic [7:0] o, input logic st);
    ia.start = s; ia.start_addr = a; ia.halt = h; ia.br_take = b; ia.br_offset = o; ia.stall = st;
  endtask

  initial begin
    drive_a(0, 8'd0, 0, 0, 8'd0, 0);
    iw.start = 0; iw.start_addr = 8'd0; iw.halt = 0; iw.br_take = 0; iw.br_offset = 8'd0; iw.stall = 0;

    //                 start addr  halt br off    stall | pc   vld rst done to cnt
    tbl[0]  = mk(1, 8'd0,   0, 0, 8'd0,   0,  8'd0,   0, 1, 0, 0, 16'd0);
    tbl[1]  = mk(0, 8'd0,   0, 0, 8'd0,   0,  8'd0,   1, 0, 0, 0, 16'd0);
    tbl[2]  = mk(0, 8'd0,   0, 0, 8'd0,   0,  8'd1,   1, 0, 0, 0, 16'd1);
    tbl[3]  = mk(0, 8'd0,   0, 0, 8'd0,   0,  8'd2,   1, 0, 0, 0, 16'd2);
    tbl[4]  = mk(0, 8'd0,   0, 0, 8'd0,   0,  8'd3,   1, 0, 0, 0, 16'd3);
    tbl[5]  = mk(0, 8'd0,   1, 0, 8'd0,   0,  8'd3,   0, 0, 1, 0, 16'd4);
    tbl[6]  = mk(0, 8'd0,   0, 0, 8'd0,   0,  8'd3,   0, 0, 1, 0, 16'd4);
    tbl[7]  = mk(1, 8'd5,   0, 0, 8'd0,   0,  8'd3,   0, 1, 0, 0, 16'd0);
    tbl[8]  = mk(1, 8'd5,   0, 0, 8'd0,   0,  8'd5,   1, 0, 0, 0, 16'd0);
    tbl[9]  = mk(1, 8'd5,   0, 1, 8'hFE,  0,  8'd3,   1, 0, 0, 0, 16'd1);
    tbl[10] = mk(0, 8'd5,   1, 1, 8'd4,   0,  8'd3,   0, 0, 1, 0, 16'd2);
    tbl[11] = mk(1, 8'd254, 0, 0, 8'd0,   0,  8'd3,   0, 1, 0, 0, 16'd0);
    tbl[12] = mk(0, 8'd254, 0, 0, 8'd0,   0,  8'd254, 1, 0, 0, 0, 16'd0);
    tbl[13] = mk(0, 8'd0,   0, 1, 8'd4,   0,  8'd2,   1, 0, 0, 0, 16'd1);
    tbl[14] = mk(0, 8'd0,   1, 0, 8'd0,   1,  8'd2,   1, 0, 0, 0, 16'd2);
    tbl[15] = mk(0, 8'd0,   1, 0, 8'd0,   1,  8'd2,   1, 0, 0, 0, 16'd3);
    tbl[16] = mk(0, 8'd0,   1, 0, 8'd0,   1,  8'd2,   1, 0, 0, 0, 16'd4);
    tbl[17] = mk(0, 8'd0,   0, 0, 8'd0,   0,  8'd3,   1, 0, 0, 0, 16'd5);
    tbl[18] = mk(0, 8'd0,   1, 0, 8'd0,   0,  8'd3,   0, 0, 1, 0, 16'd6);

    #2;
    chk6("reset_a", ia.pc, ia.instr_valid, ia.core_rst, ia.done, ia.timeout, ia.cycle_cnt,
         8'd0, 0, 0, 0, 0, 16'd0);
    chk6("reset_w", iw.pc, iw.instr_valid, iw.core_rst, iw.done, iw.timeout, iw.cycle_cnt,
         8'd0, 0, 0, 0, 0, 16'd0);
    @(negedge clk) reset = 1'b0;

    for (int i = 0; i < 19; i++) begin
      @(negedge clk);
      drive_a(tbl[i].start, tbl[i].addr, tbl[i].halt, tbl[i].br, tbl[i].off, tbl[i].stall);
      @(posedge clk); #1;
      chk6($sformatf("vec%0d", i), ia.pc, ia.instr_valid, ia.core_rst, ia.done, ia.timeout,
           ia.cycle_cnt, tbl[i].e_pc, tbl[i].e_vld, tbl[i].e_rst, tbl[i].e_done, tbl[i].e_to,
           tbl[i].e_cnt);
    end

    // Asynchronous reset in the middle of RUN, away from any edge.
    @(negedge clk) drive_a(1, 8'd40, 0, 0, 8'd0, 0);
    @(negedge clk) drive_a(0, 8'd40, 0, 0, 8'd0, 0);
    @(posedge clk); #1;
    chk("mid_run.pc", 32'(ia.pc), 32'd40);
    @(posedge clk); #1;
    chk("mid_run.pc_next", 32'(ia.pc), 32'd41);
    #3 reset = 1'b1;
    #1;
    chk6("async_rst", ia.pc, ia.instr_valid, ia.core_rst, ia.done, ia.timeout, ia.cycle_cnt,
         8'd0, 0, 0, 0, 0, 16'd0);
    @(negedge clk) reset = 1'b0;
    drive_a(1, 8'd7, 0, 0, 8'd0, 0);
    @(posedge clk); #1;
    chk6("restart_load", ia.pc, ia.instr_valid, ia.core_rst, ia.done, ia.timeout, ia.cycle_cnt,
         8'd0, 0, 1, 0, 0, 16'd0);
    @(negedge clk) drive_a(0, 8'd7, 0, 0, 8'd0, 0);
    @(posedge clk); #1;
    chk6("restart_run", ia.pc, ia.instr_valid, ia.core_rst, ia.done, ia.timeout, ia.cycle_cnt,
         8'd7, 1, 0, 0, 0, 16'd0);

    // Watchdog with MAX_CYCLES = 8: exactly 8 RUN cycles, then DONE with timeout.
    @(negedge clk) begin iw.start = 1; iw.start_addr = 8'd10; end
    @(posedge clk); #1;
    @(negedge clk) iw.start = 0;
    for (int k = 0; k < 8; k++) begin
      @(posedge clk); #1;
      chk($sformatf("wd_run%0d.pc", k), 32'(iw.pc), 32'(10 + k));
      chk($sformatf("wd_run%0d.cnt", k), 32'(iw.cycle_cnt), 32'(k));
    end
    @(posedge clk); #1;
    chk6("wd_fire", iw.pc, iw.instr_valid, iw.core_rst, iw.done, iw.timeout, iw.cycle_cnt,
         8'd17, 0, 0, 1, 1, 16'd8);
    @(posedge clk); #1;
    chk6("wd_hold", iw.pc, iw.instr_valid, iw.core_rst, iw.done, iw.timeout, iw.cycle_cnt,
         8'd17, 0, 0, 1, 1, 16'd8);

    // Restart from DONE clears done/timeout; halt on the watchdog cycle wins.
    @(negedge clk) begin iw.start = 1; iw.start_addr = 8'd20; end
    @(posedge clk); #1;
    chk6("wd_reload", iw.pc, iw.instr_valid, iw.core_rst, iw.done, iw.timeout, iw.cycle_cnt,
         8'd17, 0, 1, 0, 0, 16'd0);
    @(negedge clk) iw.start = 0;
    for (int k = 0; k < 8; k++) begin
      @(posedge clk); #1;
      chk($sformatf("wd2_run%0d.pc", k), 32'(iw.pc), 32'(20 + k));
    end
    @(negedge clk) iw.halt = 1;
    @(posedge clk); #1;
    chk6("wd_halt_wins", iw.pc, iw.instr_valid, iw.core_rst, iw.done, iw.timeout, iw.cycle_cnt,
         8'd27, 0, 0, 1, 0, 16'd8);
    @(negedge clk) iw.halt = 0;

    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end
endmodule
